ps2_kbd_tx: RTL and testbench

Device-side PS/2 transmitter that emulates a keyboard. It accepts scan-code bytes from a local writer into a small FIFO and serialises each byte onto ps2_clk/ps2_data as a standard 11-bit PS/2 frame. It drives the keyboard inputs of the existing host-side PS/2 receiver in loopback benches and FPGA self-test, and feeds the scan-code/segment display path without a physical keyboard.

---
 rtl/ps2_kbd_tx.sv | 186 ++++++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_tx.sv
// Keyboard-side PS/2 transmitter: buffers scan-code bytes in a small FIFO and
// shifts each one out as an 11-bit frame (start, d0..d7, odd parity, stop).
// ps2_data is taken straight from the LSB of the frame shift register, so both
// PS/2 lines come from flops.
module ps2_kbd_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_AW    = 3,
    parameter int GAP_HALVES = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] din,
    input  logic       wr_n,
    input  logic       inhibit,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       full,
    output logic       busy,
    output logic       overflow
);
    localparam int DEPTH    = 1 << FIFO_AW;
    localparam int GAP_CLKS = GAP_HALVES * CLK_DIV;
    localparam int TMAX     = (GAP_CLKS > CLK_DIV) ? GAP_CLKS : CLK_DIV;
    // The timer counts 0..TMAX-1.
    localparam int TW       = $clog2(TMAX);

    localparam logic [TW-1:0]    HALF_LAST = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0]    GAP_LAST  = TW'(GAP_CLKS - 1);
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] w_ptr_q, r_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overflow_q;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [3:0]         bit_q, bit_d;
    logic [10:0]        shift_q, shift_d;
    logic               clk_q, clk_d;

    logic               wr_en;
    logic               pop;
    logic               load;
    logic [7:0]         head;
    logic [10:0]        frame;

    assign full  = (count_q == DEPTH_CNT);
    assign wr_en = ~wr_n & ~full;
    // The head byte is only peeked here; it is popped once its stop bit completes,
    // so an aborted frame can be sent again from the start.
    assign head  = fifo_mem[r_ptr_q];
    assign frame = {1'b1, ~^head, head, 1'b0};

    // FIFO storage write (RAM array, no reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[w_ptr_q] <= din;
        end
    end

    // Occupancy next-state: a write and a pop in the same cycle cancel out
    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, occupancy and sticky drop flag
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            w_ptr_q    <= '0;
            r_ptr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                w_ptr_q <= w_ptr_q + 1'b1;
            end
            if (pop) begin
                r_ptr_q <= r_ptr_q + 1'b1;
            end
            count_q <= count_d;
            // A full FIFO rejects the write even if a pop frees a slot this cycle
            if (~wr_n & full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Frame sequencer next-state: half-period timing, bit stepping, inhibit abort
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        clk_d   = clk_q;
        pop     = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                load    = (count_q != '0) && !inhibit;
            end
            HIGH: begin
                if (inhibit) begin
                    state_d = GAP;
                    timer_d = '0;
                    clk_d   = 1'b1;
                    shift_d = '1;
                end else if (timer_q == HALF_LAST) begin
                    state_d = LOW;
                    timer_d = '0;
                    clk_d   = 1'b0;
                end
            end
            LOW: begin
                if (inhibit) begin
                    state_d = GAP;
                    timer_d = '0;
                    clk_d   = 1'b1;
                    shift_d = '1;
                end else if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    clk_d   = 1'b1;
                    if (bit_q == 4'd10) begin
                        pop     = 1'b1;
                        state_d = GAP;
                        shift_d = '1;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = {1'b1, shift_q[10:1]};
                        state_d = HIGH;
                    end
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                    // Starting straight from the last gap clock keeps the
                    // start-to-start spacing at exactly (22+GAP_HALVES)*CLK_DIV.
                    load    = (count_q != '0) && !inhibit;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load) begin
            state_d = HIGH;
            timer_d = '0;
            bit_d   = '0;
            shift_d = frame;
            clk_d   = 1'b1;
        end
    end

    // Frame sequencer registers; reset returns both lines to idle high
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '1;
            clk_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            clk_q   <= clk_d;
        end
    end

    assign ps2_clk  = clk_q;
    assign ps2_data = shift_q[0];
    assign busy     = (state_q != IDLE) || (count_q != '0);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: a time-based reference model predicts every output on
// every cycle, a small receiver decodes frames off the PS/2 lines, and directed
// tests pin timing, parity, FIFO limits, inhibit and reset with literal values.
module tb_ps2_kbd_tx;
    localparam int C  = 4;
    localparam int AW = 3;
    localparam int GH = 4;
    localparam int D  = 1 << AW;
    localparam int GC = GH * C;
    localparam int FR = 22 * C;

    logic       clk = 1'b0;
    logic       clrn = 1'b1;
    logic       wr_n = 1'b1;
    logic       inhibit = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ps2_clk, ps2_data, full, busy, overflow;

    ps2_kbd_tx #(.CLK_DIV(C), .FIFO_AW(AW), .GAP_HALVES(GH)) dut (
        .clk(clk), .clrn(clrn), .din(din), .wr_n(wr_n), .inhibit(inhibit),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .full(full), .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame started at edge S shows half-period h=(n-S)/C after edge n:
    // ps2_clk high on even h, data = frame bit h/2; the frame ends at S+22C and
    // the lines stay high for GH*C clocks before the next start is allowed.
    byte unsigned mq[$];
    bit           m_act = 1'b0;
    bit           m_ovf = 1'b0;
    int           m_start = 0;
    int           m_gap_end = 0;
    int           n = 0;
    logic [10:0]  m_frame = '1;
    logic         e_clk = 1'b1, e_data = 1'b1, e_busy = 1'b0, e_full = 1'b0, e_ovf = 1'b0;

    always @(posedge clk) begin
        int pre;
        int h;
        n = n + 1;
        if (!clrn) begin
            mq.delete();
            m_act = 1'b0;
            m_gap_end = 0;
            m_ovf = 1'b0;
        end else begin
            pre = mq.size();
            if (m_act && inhibit) begin
                m_act = 1'b0;
                m_gap_end = n + GC;
            end else if (m_act && n == m_start + FR) begin
                m_act = 1'b0;
                m_gap_end = n + GC;
                void'(mq.pop_front());
            end else if (!m_act && n >= m_gap_end && pre != 0 && !inhibit) begin
                m_act = 1'b1;
                m_start = n;
                m_frame = {1'b1, ~^mq[0], mq[0], 1'b0};
            end
            if (!wr_n) begin
                if (pre == D) m_ovf = 1'b1;
                else mq.push_back(din);
            end
        end
        if (m_act) begin
            h = (n - m_start) / C;
            e_clk = (h % 2 == 0);
            e_data = m_frame[h / 2];
        end else begin
            e_clk = 1'b1;
            e_data = 1'b1;
        end
        e_busy = m_act || (n < m_gap_end) || (mq.size() != 0);
        e_full = (mq.size() == D);
        e_ovf = m_ovf;
    end

    // Cycle-by-cycle comparison, 1 time unit after the active edge
    bit chk_en = 1'b0;
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("ps2_clk", ps2_clk, e_clk);
            chk("ps2_data", ps2_data, e_data);
            chk("busy", busy, e_busy);
            chk("full", full, e_full);
            chk("overflow", overflow, e_ovf);
        end
    end

    // ---------------- receiver ----------------
    int           bitcnt = 0;
    int           last_fall = -100;
    int           fall_cnt = 0;
    int           fstart = 0;
    logic [10:0]  rxsh = '0;
    logic [10:0]  rx_last = '0;
    byte unsigned rx_q[$];
    bit           rx_par[$];
    int           rx_t[$];
    int           falls[$];

    always @(negedge ps2_clk) begin
        if (cyc - last_fall > 2 * C) bitcnt = 0;
        last_fall = cyc;
        fall_cnt++;
        falls.push_back(cyc);
        if (bitcnt == 0) fstart = cyc;
        rxsh[bitcnt] = ps2_data;
        bitcnt++;
        if (bitcnt == 11) begin
            bitcnt = 0;
            rx_last = rxsh;
            rx_q.push_back(rxsh[8:1]);
            rx_par.push_back(rxsh[9]);
            rx_t.push_back(fstart);
            chk("frame_fmt", {29'd0, rxsh[10], ~rxsh[0], ^rxsh[9:1]}, 32'd7);
            $display("rx byte %02h parity %0b first fall at cycle %0d", rxsh[8:1], rxsh[9], fstart);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_rx();
        rx_q.delete();
        rx_par.delete();
        rx_t.delete();
        falls.delete();
    endtask

    task automatic wr(input logic [7:0] b, output int t);
        din = b;
        wr_n = 1'b0;
        t = cyc + 1;
        $display("wr %02h at cycle %0d", b, t);
        @(negedge clk);
        wr_n = 1'b1;
    endtask

    task automatic wait_idle(input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (!busy) begin
                at = cyc;
                break;
            end
        end
        checks++;
        if (at < 0) begin
            failures++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", limit);
        end
    endtask

    task automatic wait_falls(input int target, input int limit);
        bit ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (fall_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL fall_timeout: got %0d falls required %0d", fall_cnt, target);
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int t;
        int done;
        int base;
        #1 clrn = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_clk", ps2_clk, 1);
        chk("rst_data", ps2_data, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);

        // single byte: bit pattern, first-fall latency, fall spacing, busy length
        clear_rx();
        wr(8'h1C, t);
        wait_idle(300, done);
        chk("t1_nbytes", rx_q.size(), 1);
        chk("t1_bits", rx_last, 11'h438);
        chk("t1_nfalls", falls.size(), 11);
        if (falls.size() == 11) begin
            chk("t1_first_fall", falls[0] - t, 5);
            chk("t1_fall_span", falls[10] - falls[0], 80);
        end
        chk("t1_busy_len", done - t, 105);

        // parity corners, back-to-back spacing
        clear_rx();
        wr(8'h00, t);
        wr(8'hFF, t);
        wr(8'h01, t);
        wait_idle(600, done);
        chk("t2_nbytes", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            chk("t2_b0", rx_q[0], 8'h00);
            chk("t2_p0", rx_par[0], 1);
            chk("t2_b1", rx_q[1], 8'hFF);
            chk("t2_p1", rx_par[1], 1);
            chk("t2_b2", rx_q[2], 8'h01);
            chk("t2_p2", rx_par[2], 0);
        end

        // loopback sequence and start-to-start spacing
        clear_rx();
        wr(8'h1C, t);
        wr(8'hF0, t);
        wr(8'h1C, t);
        wait_idle(600, done);
        chk("t3_nbytes", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            chk("t3_b0", rx_q[0], 8'h1C);
            chk("t3_b1", rx_q[1], 8'hF0);
            chk("t3_b2", rx_q[2], 8'h1C);
            chk("t3_space01", rx_t[1] - rx_t[0], 104);
            chk("t3_space12", rx_t[2] - rx_t[1], 104);
        end
        chk("t3_ovf", overflow, 0);

        // fill under inhibit, drop the 9th byte, then drain
        clear_rx();
        inhibit = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            wr(8'(i), t);
            if (i == 8) chk("t4_full8", full, 1);
        end
        chk("t4_ovf", overflow, 1);
        chk("t4_no_tx", fall_cnt - fall_cnt + falls.size(), 0);
        inhibit = 1'b0;
        wait_idle(1200, done);
        chk("t4_nbytes", rx_q.size(), 8);
        for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
            chk("t4_byte", rx_q[i], 32'(i + 1));
        end
        chk("t4_ovf_sticky", overflow, 1);

        // reset mid-frame at d5
        clear_rx();
        base = fall_cnt;
        wr(8'hA5, t);
        wait_falls(base + 7, 200);
        clrn = 1'b0;
        #1;
        chk("t6_clk", ps2_clk, 1);
        chk("t6_data", ps2_data, 1);
        chk("t6_busy", busy, 0);
        chk("t6_full", full, 0);
        chk("t6_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        base = fall_cnt;
        repeat (200) @(negedge clk);
        chk("t6_silent", fall_cnt - base, 0);
        chk("t6_idle", busy, 0);

        // inhibit during LOW of d3, then full re-send
        clear_rx();
        base = fall_cnt;
        wr(8'h5A, t);
        wait_falls(base + 5, 200);
        inhibit = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_abort_clk", ps2_clk, 1);
        chk("t5_abort_data", ps2_data, 1);
        repeat (50) @(negedge clk);
        inhibit = 1'b0;
        wait_idle(400, done);
        chk("t5_nbytes", rx_q.size(), 1);
        if (rx_q.size() == 1) chk("t5_byte", rx_q[0], 8'h5A);
        chk("t5_full", full, 0);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
